regfile_2r2w_bypass: RTL
========================

Name: regfile_2r2w_bypass

Overview:
- Parametrised successor to the current two-read/two-write register file for the Y86-style datapath.
- Two read ports (srcA/srcB) and two write ports (E = ALU result, M = memory result).
- Adds synchronous reset, a "no register" encoding, deterministic M-over-E write priority, optional write-to-read bypass, and an optional registered-read mode with read enable.
- Sits between decode (reads) and write-back (writes); in registered mode the outputs feed the D/E pipeline register directly.

Parameters:
- DATA_WID, 32, width of every register and data port.
- ADDR_WID, 4, width of every register address.
- NUM_OF_REG, 15, number of physical registers (0 .. NUM_OF_REG-1); must be ≤ 2^ADDR_WID - 1.
- RNONE, 2^ADDR_WID - 1 (4'hF at defaults), address meaning "no register".
- BYPASS, 1, 1 = same-cycle write data forwarded to reads; 0 = reads return stored contents only.
- REG_READ, 0, 0 = combinational read; 1 = read data registered, 1-cycle latency.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RST  input  1  synchronous reset, active-high.
- srcA  input  ADDR_WID  read address, port A.
- srcB  input  ADDR_WID  read address, port B.
- RD_EN  input  1  read enable; used only when REG_READ=1, ignored otherwise.
- valA  output  DATA_WID  read data, port A.
- valB  output  DATA_WID  read data, port B.
- destE  input  ADDR_WID  write address, E port.
- valE  input  DATA_WID  write data, E port.
- destM  input  ADDR_WID  write address, M port.
- valM  input  DATA_WID  write data, M port.

Behaviour:
- Valid address: addr < NUM_OF_REG. Any other value, including RNONE, is "none".
- Writes (rising CLK, RST=0):
  - data[destE] <= valE if destE is valid.
  - data[destM] <= valM if destM is valid.
  - destE == destM, both valid: only valM is stored; valE is discarded.
  - A "none" destination writes nothing and causes no error.
- Reset (rising CLK with RST=1):
  - All NUM_OF_REG registers cleared to 0.
  - Writes presented in the same cycle are ignored; reset has priority.
  - REG_READ=1: valA/valB registers cleared to 0.
- Read value rd(src), evaluated per port:
  - src is "none": 0.
  - BYPASS=1 and src == destM (valid): valM.
  - Else BYPASS=1 and src == destE (valid): valE.
  - Otherwise: data[src].
  - Bypass is suppressed while RST=1; rd returns the stored value (0 after the reset edge).
- REG_READ=0:
  - valA = rd(srcA), valB = rd(srcB), purely combinational.
  - Outputs follow any change on src*, dest* or val* within the same cycle.
  - No clock edge is needed to update them.
- REG_READ=1:
  - On rising CLK with RST=0 and RD_EN=1: valA <= rd(srcA), valB <= rd(srcB).
  - RD_EN=0: valA/valB hold their previous values (decode stall).
  - Latency is 1 cycle from address to data.
  - A write and a read of the same register in one cycle yields the new value with BYPASS=1 and the old value with BYPASS=0.
- Both read ports may address the same register; both return identical data.
- Register contents persist indefinitely without writes; no other side effects.
- No simulation-only $display output in synthesised paths.

Test Plan:
- Reset clear: write 32'hDEADBEEF to r3; assert RST 1 cycle; read srcA=3 → valA=0. Repeat with RST asserted together with destE=3, valE=32'h11 → r3 stays 0.
- Dual write, distinct destinations: destE=2/valE=32'h0000_00AA, destM=5/valM=32'h0000_0055 in one cycle; next cycle srcA=2, srcB=5 → valA=32'hAA, valB=32'h55.
- Same-destination priority: destE=destM=4, valE=32'h1111_1111, valM=32'h2222_2222; next cycle read r4 → 32'h2222_2222.
- RNONE handling: destE=4'hF, valE=32'hFFFF_FFFF leaves all registers unchanged (sweep read r0..r14); srcA=4'hF → valA=0 while destM=4'hF with any valM.
- Bypass (BYPASS=1, REG_READ=0): r6=32'h10, then present destE=6, valE=32'h20 with srcA=6 → valA=32'h20 in the same cycle before the edge. With BYPASS=0 → valA=32'h10 until after the edge.
- Registered read (REG_READ=1): srcA=1 with r1=32'h77, RD_EN=1 → valA=32'h77 one cycle later. Drop RD_EN, change srcA to 2 (r2=32'h99) → valA holds 32'h77. Raise RD_EN → valA=32'h99 on the next edge.

Source files
------------

// File: rtl/regfile_2r2w_bypass.sv
// Two-read / two-write register file for the Y86-style datapath.
// M-port writes win over E-port writes; optional same-cycle bypass and registered reads.
module regfile_2r2w_bypass #(
    parameter int DATA_WID   = 32,
    parameter int ADDR_WID   = 4,
    parameter int NUM_OF_REG = 15,
    parameter int RNONE      = (1 << ADDR_WID) - 1,
    parameter int BYPASS     = 1,
    parameter int REG_READ   = 0
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic [ADDR_WID-1:0] srcA,
    input  logic [ADDR_WID-1:0] srcB,
    input  logic                RD_EN,
    output logic [DATA_WID-1:0] valA,
    output logic [DATA_WID-1:0] valB,
    input  logic [ADDR_WID-1:0] destE,
    input  logic [DATA_WID-1:0] valE,
    input  logic [ADDR_WID-1:0] destM,
    input  logic [DATA_WID-1:0] valM
);

    localparam logic [ADDR_WID-1:0] NREG  = ADDR_WID'(NUM_OF_REG);
    localparam logic [ADDR_WID-1:0] NONE  = ADDR_WID'(RNONE);

    logic [DATA_WID-1:0] data [NUM_OF_REG];
    logic [DATA_WID-1:0] rdA;
    logic [DATA_WID-1:0] rdB;
    logic [DATA_WID-1:0] valAQ;
    logic [DATA_WID-1:0] valBQ;
    logic                validE;
    logic                validM;

    function automatic logic isValid(input logic [ADDR_WID-1:0] addr);
        return (addr != NONE) && (addr < NREG);
    endfunction

    assign validE = isValid(destE);
    assign validM = isValid(destM);

    // Storage: reset wins over writes; on a shared destination only valM lands.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < NUM_OF_REG; i++) begin
                data[i] <= '0;
            end
        end else begin
            if (validE && !(validM && (destE == destM))) begin
                data[destE] <= valE;
            end
            if (validM) begin
                data[destM] <= valM;
            end
        end
    end

    function automatic logic [DATA_WID-1:0] readPort(input logic [ADDR_WID-1:0] src);
        logic [DATA_WID-1:0] result;
        result = '0;
        if (isValid(src)) begin
            if ((BYPASS != 0) && !RST && validM && (src == destM)) begin
                result = valM;
            end else if ((BYPASS != 0) && !RST && validE && (src == destE)) begin
                result = valE;
            end else begin
                result = data[src];
            end
        end
        return result;
    endfunction

    always_comb begin
        rdA = readPort(srcA);
        rdB = readPort(srcB);
    end

    // Registered read path; RD_EN low holds the outputs while decode is stalled.
    always_ff @(posedge CLK) begin
        if (RST) begin
            valAQ <= '0;
            valBQ <= '0;
        end else if (RD_EN) begin
            valAQ <= rdA;
            valBQ <= rdB;
        end
    end

    assign valA = (REG_READ != 0) ? valAQ : rdA;
    assign valB = (REG_READ != 0) ? valBQ : rdB;

endmodule
